// File: rtl/window_dot_product_pkg.sv
// Shared constants and types for the window datapath (memory/router stage and dot-product stage).
// Sum width covers MaxWidth full-precision products without overflow.
package window_dot_product_pkg;

    localparam int MaxWidth  = 9;
    localparam int DataWidth = 8;
    localparam int AccWidth  = 32;
    localparam int ProdWidth = 2 * DataWidth;
    localparam int SumWidth  = ProdWidth + $clog2(MaxWidth);
    localparam int CntWidth  = $clog2(MaxWidth);

    typedef enum logic {
        LOADING,
        READY
    } loadStateT;

    typedef struct packed {
        logic accClear;
        logic lastWindow;
    } frameT;

    function automatic logic [CntWidth-1:0] nextSlot(input logic [CntWidth-1:0] cnt);
        return (cnt == CntWidth'(MaxWidth - 1)) ? '0 : cnt + CntWidth'(1);
    endfunction

endpackage

// File: rtl/window_dot_product_adder_tree.sv
// Combinational signed reduction of N operands; the output is wide enough that the sum
// of N full-scale operands can never overflow.
module adder_tree #(
    parameter int N       = 9,
    parameter int InWidth = 16
) (
    input  logic signed [InWidth-1:0]             operands [N],
    output logic signed [InWidth+$clog2(N)-1:0]   sum
);

    localparam int OutWidth = InWidth + $clog2(N);

    logic signed [OutWidth-1:0] total;

    always_comb begin
        total = '0;
        for (int i = 0; i < N; i++) begin
            total = total + OutWidth'(operands[i]);
        end
        sum = total;
    end

endmodule

// File: rtl/window_dot_product.sv
// Three-stage windowed dot product (multiply, reduce, accumulate) against a serially
// loaded weight vector, producing one signed result per accumulation group.
module window_dot_product
    import window_dot_product_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              weightEn,
    input  logic [DataWidth-1:0]              weightIn,
    input  logic                              windowValid,
    input  logic [MaxWidth*DataWidth-1:0]     windowIn,
    input  logic                              accClear,
    input  logic                              lastWindow,
    output logic                              weightsReady,
    output logic                              busy,
    output logic                              resultValid,
    output logic signed [AccWidth-1:0]        result
);

    loadStateT                    state;
    loadStateT                    stateNext;
    logic [CntWidth-1:0]          cnt;
    logic signed [DataWidth-1:0]  weights [MaxWidth];
    logic signed [DataWidth-1:0]  elems   [MaxWidth];
    logic                         accept;

    logic signed [ProdWidth-1:0]  prod_p1 [MaxWidth];
    frameT                        frame_p1;
    logic                         vld_p1;

    logic signed [SumWidth-1:0]   treeSum;
    logic signed [SumWidth-1:0]   sum_p2;
    frameT                        frame_p2;
    logic                         vld_p2;

    logic                         vld_p3;
    logic signed [AccWidth-1:0]   acc;
    logic signed [AccWidth-1:0]   accNext;

    function automatic logic signed [ProdWidth-1:0] mulFull(
        input logic signed [DataWidth-1:0] a,
        input logic signed [DataWidth-1:0] b
    );
        return ProdWidth'(a) * ProdWidth'(b);
    endfunction

    function automatic logic signed [AccWidth-1:0] extendSum(input logic signed [SumWidth-1:0] s);
        return {{(AccWidth - SumWidth){s[SumWidth-1]}}, s};
    endfunction

    // Accumulation wraps modulo 2^AccWidth; no saturation is applied.
    function automatic logic signed [AccWidth-1:0] wrapAdd(
        input logic signed [AccWidth-1:0] a,
        input logic signed [AccWidth-1:0] b
    );
        return a + b;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOADING;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            LOADING: if (weightEn && cnt == CntWidth'(MaxWidth - 1)) stateNext = READY;
            READY:   if (weightEn) stateNext = LOADING;
            default: stateNext = LOADING;
        endcase
    end

    assign weightsReady = (state == READY);
    assign accept       = windowValid && weightsReady;

    // A reload starts with cnt already wrapped to 0, so it lands in slot 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            for (int i = 0; i < MaxWidth; i++) begin
                weights[i] <= '0;
            end
        end else if (weightEn) begin
            weights[cnt] <= weightIn;
            cnt          <= nextSlot(cnt);
        end
    end

    always_comb begin
        for (int i = 0; i < MaxWidth; i++) begin
            elems[i] = windowIn[i*DataWidth +: DataWidth];
        end
    end

    // Stage 1: element-wise products against the weights as they stood before this edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            frame_p1 <= '{accClear: accClear, lastWindow: lastWindow};
            for (int i = 0; i < MaxWidth; i++) begin
                prod_p1[i] <= mulFull(elems[i], weights[i]);
            end
        end
    end

    // Stage 2: reduce the products.
    adder_tree #(
        .N       (MaxWidth),
        .InWidth (ProdWidth)
    ) u_adderTree (
        .operands (prod_p1),
        .sum      (treeSum)
    );

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            sum_p2   <= treeSum;
            frame_p2 <= frame_p1;
        end
    end

    // Stage 3: accumulate and publish on the group's last window.
    always_comb begin
        accNext = frame_p2.accClear ? extendSum(sum_p2) : wrapAdd(acc, extendSum(sum_p2));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            vld_p3      <= 1'b0;
            acc         <= '0;
            result      <= '0;
            resultValid <= 1'b0;
        end else begin
            vld_p1      <= accept;
            vld_p2      <= vld_p1;
            vld_p3      <= vld_p2;
            resultValid <= vld_p2 && frame_p2.lastWindow;
            if (vld_p2) begin
                acc <= accNext;
                if (frame_p2.lastWindow) begin
                    result <= accNext;
                end
            end
        end
    end

    assign busy = vld_p1 || vld_p2 || vld_p3;

endmodule
